// File: rtl/dff_bank_pkg.sv
// Shared definitions for the DFF shift bank: mode encoding and occupancy width.
package dff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_HOLD   = 2'd1,
        MODE_LOAD   = 2'd2,
        MODE_ROTATE = 2'd3
    } mode_e;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_shift_chan.sv
// One channel of the bank: DEPTH data stages with per-stage valid bits and a
// registered occupancy count. Enable arrives already resolved to active-high.
module dff_shift_chan
    import dff_bank_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int SR_VAL = 0,
    parameter int INIT   = 0,
    localparam int OW    = occ_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sr,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [OW-1:0]    occ
);

    localparam logic [WIDTH-1:0] SR_PAT   = (SR_VAL != 0) ? {WIDTH{1'b1}} : '0;
    localparam logic [WIDTH-1:0] INIT_PAT = (INIT   != 0) ? {WIDTH{1'b1}} : '0;

    logic [DEPTH-1:0][WIDTH-1:0] stg, stg_nxt;
    logic [DEPTH-1:0]            vld_pipe, vld_nxt;
    logic [OW-1:0]               occ_nxt;

    always_comb begin
        stg_nxt = stg;
        vld_nxt = vld_pipe;
        if (sr) begin
            stg_nxt = {DEPTH{SR_PAT}};
            vld_nxt = '0;
        end else if (en) begin
            case (mode)
                MODE_SHIFT: begin
                    for (int k = DEPTH-1; k > 0; k--) begin
                        stg_nxt[k] = stg[k-1];
                        vld_nxt[k] = vld_pipe[k-1];
                    end
                    stg_nxt[0] = d;
                    vld_nxt[0] = d_valid;
                end
                MODE_HOLD: ;
                MODE_LOAD: begin
                    stg_nxt = {DEPTH{d}};
                    vld_nxt = {DEPTH{d_valid}};
                end
                MODE_ROTATE: begin
                    for (int k = DEPTH-1; k > 0; k--) begin
                        stg_nxt[k] = stg[k-1];
                        vld_nxt[k] = vld_pipe[k-1];
                    end
                    stg_nxt[0] = stg[DEPTH-1];
                    vld_nxt[0] = vld_pipe[DEPTH-1];
                end
            endcase
        end
    end

    // Count from the next-state valid bits so occ lands on the same edge.
    always_comb begin
        occ_nxt = '0;
        for (int k = 0; k < DEPTH; k++)
            occ_nxt = occ_nxt + OW'(vld_nxt[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg      <= {DEPTH{INIT_PAT}};
            vld_pipe <= '0;
            occ      <= '0;
        end else begin
            stg      <= stg_nxt;
            vld_pipe <= vld_nxt;
            occ      <= occ_nxt;
        end
    end

    assign q       = stg[DEPTH-1];
    assign q_valid = vld_pipe[DEPTH-1];

endmodule

// File: rtl/dff_shift_bank.sv
// Bank of CHANNELS independent shift/rotate register channels sharing one mode.
// Enable polarity is normalised here so channels only ever see active-high.
module dff_shift_bank
    import dff_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int CHANNELS = 2,
    parameter int EN_INV   = 0,
    parameter int SR_VAL   = 0,
    parameter int INIT     = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNELS-1:0]                  en,
    input  logic [CHANNELS-1:0]                  sr,
    input  logic [1:0]                           mode,
    input  logic [CHANNELS*WIDTH-1:0]            d,
    input  logic [CHANNELS-1:0]                  d_valid,
    output logic [CHANNELS*WIDTH-1:0]            q,
    output logic [CHANNELS-1:0]                  q_valid,
    output logic [CHANNELS*$clog2(DEPTH+1)-1:0]  occ
);

    localparam int OW = occ_w(DEPTH);

    logic [CHANNELS-1:0] en_act;
    mode_e               mode_s;

    assign en_act = (EN_INV != 0) ? ~en : en;
    assign mode_s = mode_e'(mode);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        dff_shift_chan #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .SR_VAL (SR_VAL),
            .INIT   (INIT)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en_act[c]),
            .sr      (sr[c]),
            .mode    (mode_s),
            .d       (d[c*WIDTH +: WIDTH]),
            .d_valid (d_valid[c]),
            .q       (q[c*WIDTH +: WIDTH]),
            .q_valid (q_valid[c]),
            .occ     (occ[c*OW +: OW])
        );
    end

endmodule
